mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage feeding the write-back stage over the `ms_to_ws` valid/allow-in handshake. Accepts an instruction from EX, waits for the data-RAM response when EX issued a load, aligns and extends load data, then presents `{rf_we, dest, pc, final_result}` to WB. Also drives a forwarding/hazard bus back to ID.

## Interface
- `ES_TO_MS_WD`, 75, EX→MEM bus width: `{res_from_mem[74], ld_op[73:71], req_issued[70], rf_we[69], dest[68:64], pc[63:32], alu_result[31:0]}`
- `MS_TO_WS_WD`, 70, MEM→WB bus width: `{rf_we[69], dest[68:64], pc[63:32], final_result[31:0]}`
- `clk  in  1  clock; all state updates on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `es_to_ms_valid  in  1  EX holds a valid instruction`
- `es_to_ms_bus  in  ES_TO_MS_WD  EX payload`
- `ms_allow_in  out  1  MEM accepts from EX this cycle`
- `data_sram_data_ok  in  1  load/store response valid (one pulse per issued request)`
- `data_sram_rdata  in  32  response data, valid with data_ok`
- `ms_to_ws_valid  out  1  MEM presents a completed instruction`
- `ms_to_ws_bus  out  MS_TO_WS_WD  MEM payload to WB`
- `ws_allow_in  in  1  WB accepts this cycle`
- `ms_fwd_bus  out  39  `{fwd_we[38], load_pending[37], dest[36:32], result[31:0]}` to ID`

## Operation
- States: EMPTY (no instruction), WAIT (valid, `req_issued`=1, response not yet received), READY (valid, result available: either `req_issued`=0 or response latched).
- `ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in)`. When it is 1, the stage loads `es_to_ms_valid`. The payload register captures only when `es_to_ms_valid && ms_allow_in`.
- On entry: `req_issued`=1 → WAIT; otherwise → READY.
- `ms_ready_go` = 1 in READY; in WAIT it equals `data_sram_data_ok`.
- WAIT + `data_ok` + `ws_allow_in`: the result uses live `data_sram_rdata` and hands off in the same cycle. The next state is WAIT/READY/EMPTY per the incoming EX instruction.
- WAIT + `data_ok` + `!ws_allow_in`: latch `rdata` into a 32-bit buffer and go to READY. Later hand-off uses the buffer.
- READY + `ws_allow_in`: hand off. The next state follows the incoming EX instruction or goes to EMPTY.
- `data_ok` in EMPTY or READY is ignored. It never overwrites the buffer.
- Load alignment uses `a = alu_result[1:0]`:
  - `ld_op`=000 (ld.w): full word; `a` ignored.
  - `ld_op`=001 (ld.b): sign-extend byte `rdata[8a+7:8a]`.
  - `ld_op`=010 (ld.bu): zero-extend that byte.
  - `ld_op`=011 (ld.h): sign-extend half `rdata[16*a[1]+15:16*a[1]]`.
  - `ld_op`=100 (ld.hu): zero-extend that half.
  - Other `ld_op` values are treated as ld.w.
- `final_result = res_from_mem ? load_data : alu_result`.
- `ms_to_ws_bus = {rf_we, dest, pc, final_result}`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- Forwarding bus:
  - `fwd_we = ms_valid && rf_we`.
  - `load_pending = (state==WAIT) && !data_sram_data_ok`.
  - `result = final_result`.

## Timing
- Reset (`rst_n`=0, async): state EMPTY, `ms_valid`=0, payload and buffer cleared to 0. Resulting outputs:
  - `ms_allow_in`=1, `ms_to_ws_valid`=0, `ms_to_ws_bus`=0, `ms_fwd_bus`=0.
- Non-load latency: accepted at edge N, `ms_to_ws_valid`=1 in cycle N+1.
- Load latency: `ms_to_ws_valid` asserts in the cycle `data_ok` arrives (combinational path `data_ok`→`ms_to_ws_valid`/bus). It stays asserted until `ws_allow_in`.
- While `ms_to_ws_valid && !ws_allow_in`, `ms_to_ws_bus` is stable cycle to cycle.
- Back-to-back: with `ws_allow_in`=1 constantly, non-load instructions stream one per cycle with no bubbles.
- Reset asserted mid-WAIT discards the instruction. A `data_ok` arriving after reset release, while EMPTY, is ignored.

## Test plan
- Reset sequence: hold `rst_n`=0 for 3 cycles, release → `ms_allow_in`=1, `ms_to_ws_valid`=0, both buses 0.
- ALU op streaming:
  - Stimulus: 4 consecutive non-load instructions, `alu_result`=0x10..0x13, `ws_allow_in`=1.
  - Required: `ms_to_ws_valid`=1 for 4 consecutive cycles with `final_result` 0x10..0x13 in order, one cycle after each accept.
- ld.b sign-extend with delayed response:
  - Stimulus: `alu_result`=0x1002, `data_ok` after 3 cycles, `rdata`=0x1280_3456.
  - Required: `load_pending`=1 for 3 cycles; on the `data_ok` cycle `final_result`=0xFFFF_FF80; `ms_allow_in`=0 while waiting.
- Response with WB stalled:
  - Stimulus: ld.hu at `alu_result`=0x2, `rdata`=0xBEEF_0000 with `ws_allow_in`=0, then `rdata`=0x0 afterwards; release `ws_allow_in` 2 cycles later.
  - Required: `final_result` stays 0x0000_BEEF throughout; one hand-off occurs.
- Spurious `data_ok` in READY:
  - Stimulus: `rdata`=0xDEAD_BEEF in READY holding a non-load with `alu_result`=0x5.
  - Required: `final_result` remains 0x5.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n`=0 while in WAIT, release, then pulse `data_ok`.
  - Required: `ms_to_ws_valid` stays 0; the stage accepts the next EX instruction normally.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage. It takes one instruction from EX, waits for
//   the data-RAM response if EX issued a load, then aligns and extends the load
//   data. The completed instruction goes to WB over a valid/allow-in handshake.
//   A forwarding/hazard bus is also returned to ID.
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   es_to_ms_valid     in   EX holds a valid instruction
//   es_to_ms_bus       in   {res_from_mem, ld_op[2:0], req_issued, rf_we,
//                            dest[4:0], pc[31:0], alu_result[31:0]}
//   ms_allow_in        out  MEM accepts from EX this cycle
//   data_sram_data_ok  in   data-RAM response strobe
//   data_sram_rdata    in   data-RAM response data
//   ms_to_ws_valid     out  MEM presents a completed instruction
//   ms_to_ws_bus       out  {rf_we, dest[4:0], pc[31:0], final_result[31:0]}
//   ws_allow_in        in   WB accepts this cycle
//   ms_fwd_bus         out  {fwd_we, load_pending, dest[4:0], result[31:0]}
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_WD = 75,
    parameter int MS_TO_WS_WD = 70
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic                   ms_allow_in,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    input  logic                   ws_allow_in,
    output logic [38:0]            ms_fwd_bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READY = 2'b10
    } state_t;

    // Aligns and extends a load word; unknown ld_op codes behave as ld.w.
    function automatic logic [31:0] f_load_align(
        input logic [2:0]  op,
        input logic [1:0]  a,
        input logic [31:0] d
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (a)
            2'b00:   v_byte = d[7:0];
            2'b01:   v_byte = d[15:8];
            2'b10:   v_byte = d[23:16];
            2'b11:   v_byte = d[31:24];
            default: v_byte = d[7:0];
        endcase
        if (a[1]) begin
            v_half = d[31:16];
        end else begin
            v_half = d[15:0];
        end
        case (op)
            3'b001:  v_res = {{24{v_byte[7]}}, v_byte};
            3'b010:  v_res = {24'h00_0000, v_byte};
            3'b011:  v_res = {{16{v_half[15]}}, v_half};
            3'b100:  v_res = {16'h0000, v_half};
            default: v_res = d;
        endcase
        return v_res;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    // req_issued only steers the entry state, so it is not kept in the payload.
    logic [73:0] r_payload;
    logic [31:0] r_buf;

    logic        w_res_from_mem;
    logic [2:0]  w_ld_op;
    logic        w_rf_we;
    logic [4:0]  w_dest;
    logic [31:0] w_pc;
    logic [31:0] w_alu_result;
    logic        w_valid;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_buf_load;
    logic [31:0] w_mem_word;
    logic [31:0] w_final_result;

    assign w_res_from_mem = r_payload[73];
    assign w_ld_op        = r_payload[72:70];
    assign w_rf_we        = r_payload[69];
    assign w_dest         = r_payload[68:64];
    assign w_pc           = r_payload[63:32];
    assign w_alu_result   = r_payload[31:0];

    assign w_valid     = (r_state != ST_EMPTY);
    assign ms_allow_in = !w_valid || (w_ready_go && ws_allow_in);
    assign w_accept    = es_to_ms_valid && ms_allow_in;
    // Response arrives while WB stalls: keep it, since rdata is only valid now.
    assign w_buf_load  = (r_state == ST_WAIT) && data_sram_data_ok && !ws_allow_in;

    // Ready-to-go and load-word source: live response in WAIT, buffer otherwise.
    always_comb begin
        w_ready_go = 1'b0;
        w_mem_word = r_buf;
        case (r_state)
            ST_WAIT: begin
                w_ready_go = data_sram_data_ok;
                w_mem_word = data_sram_rdata;
            end
            ST_READY: begin
                w_ready_go = 1'b1;
                w_mem_word = r_buf;
            end
            default: begin
                w_ready_go = 1'b0;
                w_mem_word = r_buf;
            end
        endcase
    end

    // Result selection between aligned load data and the ALU result.
    always_comb begin
        w_final_result = w_alu_result;
        if (w_res_from_mem) begin
            w_final_result = f_load_align(w_ld_op, w_alu_result[1:0], w_mem_word);
        end else begin
            w_final_result = w_alu_result;
        end
    end

    // Next-state logic: a hand-off slot refills from EX; a stalled response parks in READY.
    always_comb begin
        w_state_nxt = r_state;
        if (ms_allow_in) begin
            if (es_to_ms_valid) begin
                if (es_to_ms_bus[70]) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_READY;
                end
            end else begin
                w_state_nxt = ST_EMPTY;
            end
        end else if (w_buf_load) begin
            w_state_nxt = ST_READY;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload register, loaded on accept from EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= 74'd0;
        end else if (w_accept) begin
            r_payload <= {es_to_ms_bus[74:71], es_to_ms_bus[69:0]};
        end else begin
            r_payload <= r_payload;
        end
    end

    // Response buffer; written only from WAIT, so stray data_ok cannot corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= 32'd0;
        end else if (w_buf_load) begin
            r_buf <= data_sram_rdata;
        end else begin
            r_buf <= r_buf;
        end
    end

    assign ms_to_ws_valid = w_valid && w_ready_go;
    assign ms_to_ws_bus   = {w_rf_we, w_dest, w_pc, w_final_result};
    assign ms_fwd_bus     = {w_valid && w_rf_we,
                             (r_state == ST_WAIT) && !data_sram_data_ok,
                             w_dest,
                             w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ws_allow_in;
    logic [38:0] ms_fwd_bus;

    int          n_total;
    int          n_bad;
    int          n_handoff;
    logic [69:0] exp_q[$];
    logic        prev_stall;
    logic [69:0] prev_bus;

    mem_stage #(.ES_TO_MS_WD(75), .MS_TO_WS_WD(70)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allow_in       (ms_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allow_in       (ws_allow_in),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] mk_es(input logic rfm, input logic [2:0] op, input logic req,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] pc, input logic [31:0] alu);
        return {rfm, op, req, we, dst, pc, alu};
    endfunction

    // Reference load extension written straight from the ld_op table.
    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*int'(a) +: 8];
        h = d[16*int'(a[1]) +: 16];
        if (op == 3'd1) return {{24{b[7]}}, b};
        else if (op == 3'd2) return {24'd0, b};
        else if (op == 3'd3) return {{16{h[15]}}, h};
        else if (op == 3'd4) return {16'd0, h};
        else return d;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every hand-off pops one expected WB payload; stalled payloads must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check_eq("stall_valid", {69'd0, ms_to_ws_valid}, 70'd1);
                check_eq("stall_bus", ms_to_ws_bus, prev_bus);
            end
            if (ms_to_ws_valid && ws_allow_in) begin
                n_handoff = n_handoff + 1;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_handoff", ms_to_ws_bus, 70'd0 ^ ~ms_to_ws_bus);
                end else begin
                    check_eq("wb_bus", ms_to_ws_bus, exp_q.pop_front());
                end
            end
            prev_stall = ms_to_ws_valid && !ws_allow_in;
            prev_bus   = ms_to_ws_bus;
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [2:0]  ops [8];
    logic [31:0] rds [8];
    int          hc0;

    initial begin
        n_total = 0; n_bad = 0; n_handoff = 0; prev_stall = 1'b0; prev_bus = 70'd0;
        rst_n = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = 75'd0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; ws_allow_in = 1'b1;
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd1, 3'd3};
        rds = '{32'h8081_7F82, 32'hFF00_7F80, 32'h1234_ABCD, 32'h8000_8000,
                32'h7FFF_FFFF, 32'hCAFE_F00D, 32'h0180_8001, 32'hA5A5_5A5A};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_allow_in", {69'd0, ms_allow_in}, 70'd1);
        check_eq("rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        check_eq("rst_bus", ms_to_ws_bus, 70'd0);
        check_eq("rst_fwd", {31'd0, ms_fwd_bus}, 70'd0);

        // ALU streaming, one per cycle
        for (int i = 0; i <= 4; i++) begin
            next_cycle();
            if (i < 4) begin
                es_to_ms_valid = 1'b1;
                es_to_ms_bus = mk_es(1'b0, 3'd0, 1'b0, 1'b1, 5'(i + 1), 32'h1C00_0000 + 32'(4 * i), 32'h10 + 32'(i));
                exp_q.push_back({1'b1, 5'(i + 1), 32'h1C00_0000 + 32'(4 * i), 32'h10 + 32'(i)});
            end else begin
                es_to_ms_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("alu_allow_in", {69'd0, ms_allow_in}, 70'd1);
            if (i > 0) begin
                check_eq("alu_valid", {69'd0, ms_to_ws_valid}, 70'd1);
                check_eq("alu_result", {38'd0, ms_to_ws_bus[31:0]}, 70'h10 + 70'(i - 1));
                check_eq("alu_fwd", {31'd0, ms_fwd_bus[38:32]}, {63'd0, 2'b10, 5'(i)});
            end
        end
        next_cycle();
        @(negedge clk);
        check_eq("alu_drain", {69'd0, ms_to_ws_valid}, 70'd0);

        // ld.b with response three cycles late
        next_cycle();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 3'd1, 1'b1, 1'b1, 5'd5, 32'h1C00_0100, 32'h0000_1002);
        exp_q.push_back({1'b1, 5'd5, 32'h1C00_0100, 32'hFFFF_FF80});
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            es_to_ms_valid = 1'b0;
            @(negedge clk);
            check_eq("ldb_pending", {69'd0, ms_fwd_bus[37]}, 70'd1);
            check_eq("ldb_allow_in", {69'd0, ms_allow_in}, 70'd0);
            check_eq("ldb_wait_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        end
        next_cycle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1280_3456;
        @(negedge clk);
        check_eq("ldb_valid", {69'd0, ms_to_ws_valid}, 70'd1);
        check_eq("ldb_result", {38'd0, ms_to_ws_bus[31:0]}, 70'hFFFF_FF80);
        check_eq("ldb_pending_off", {69'd0, ms_fwd_bus[37]}, 70'd0);
        next_cycle();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        @(negedge clk);
        check_eq("ldb_done", {69'd0, ms_to_ws_valid}, 70'd0);

        // ld.hu with WB stalled at response time
        hc0 = n_handoff;
        next_cycle();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 3'd4, 1'b1, 1'b1, 5'd6, 32'h1C00_0200, 32'h0000_0002);
        exp_q.push_back({1'b1, 5'd6, 32'h1C00_0200, 32'h0000_BEEF});
        @(negedge clk);
        next_cycle();
        es_to_ms_valid = 1'b0; ws_allow_in = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
        @(negedge clk);
        check_eq("ldhu_result0", {38'd0, ms_to_ws_bus[31:0]}, 70'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
            ws_allow_in = (i == 2);
            @(negedge clk);
            check_eq("ldhu_result", {38'd0, ms_to_ws_bus[31:0]}, 70'h0000_BEEF);
        end
        next_cycle();
        @(negedge clk);
        check_eq("ldhu_handoffs", 70'(n_handoff - hc0), 70'd1);
        check_eq("ldhu_done", {69'd0, ms_to_ws_valid}, 70'd0);

        // Stray data_ok while READY holds a non-load
        next_cycle();
        ws_allow_in = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b0, 3'd0, 1'b0, 1'b1, 5'd7, 32'h1C00_0300, 32'h0000_0005);
        exp_q.push_back({1'b1, 5'd7, 32'h1C00_0300, 32'h0000_0005});
        @(negedge clk);
        next_cycle();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("spur_result", {38'd0, ms_to_ws_bus[31:0]}, 70'h5);
        next_cycle();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check_eq("spur_result2", {38'd0, ms_to_ws_bus[31:0]}, 70'h5);
        next_cycle();
        ws_allow_in = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_eq("spur_done", {69'd0, ms_to_ws_valid}, 70'd0);

        // Back-to-back loads with next-cycle responses across all ld_op codes and offsets
        for (int i = 0; i <= 8; i++) begin
            next_cycle();
            if (i < 8) begin
                es_to_ms_valid = 1'b1;
                es_to_ms_bus = mk_es(1'b1, ops[i], 1'b1, 1'b1, 5'(8 + i), 32'h1C00_0400 + 32'(4 * i), 32'h0000_4000 + 32'(i % 4));
                exp_q.push_back({1'b1, 5'(8 + i), 32'h1C00_0400 + 32'(4 * i), m_load(ops[i], 2'(i % 4), rds[i])});
            end else begin
                es_to_ms_valid = 1'b0;
            end
            data_sram_data_ok = (i > 0);
            data_sram_rdata = (i > 0) ? rds[i - 1] : 32'd0;
            @(negedge clk);
            check_eq("ld_allow_in", {69'd0, ms_allow_in}, 70'd1);
        end
        next_cycle();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        @(negedge clk);
        check_eq("ld_drain", {69'd0, ms_to_ws_valid}, 70'd0);

        // Reset while waiting for a response
        next_cycle();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 3'd0, 1'b1, 1'b1, 5'd20, 32'h1C00_0500, 32'h0000_0010);
        @(negedge clk);
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_pending", {69'd0, ms_fwd_bus[37]}, 70'd1);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rw_in_reset_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        next_cycle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        @(negedge clk);
        check_eq("rw_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        check_eq("rw_allow_in", {69'd0, ms_allow_in}, 70'd1);
        check_eq("rw_pending_off", {69'd0, ms_fwd_bus[37]}, 70'd0);
        next_cycle();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b0, 3'd0, 1'b0, 1'b1, 5'd21, 32'h1C00_0600, 32'h0000_0077);
        exp_q.push_back({1'b1, 5'd21, 32'h1C00_0600, 32'h0000_0077});
        @(negedge clk);
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_next_valid", {69'd0, ms_to_ws_valid}, 70'd1);
        check_eq("rw_next_result", {38'd0, ms_to_ws_bus[31:0]}, 70'h77);
        next_cycle();
        @(negedge clk);

        check_eq("sb_empty", 70'(exp_q.size()), 70'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
